// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one 2-cycle multiply-add unit among NUM_REQ requesters.
// In-flight ops are tagged; results land in a credit-protected FIFO drained by valid/ready.
module mac_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned A_W        = 18,
    parameter int unsigned C_W        = 36,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_W       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*A_W-1:0] req_b,
    input  logic [NUM_REQ*C_W-1:0] req_c,
    output logic [A_W-1:0]         mul_a,
    output logic [A_W-1:0]         mul_b,
    output logic [C_W-1:0]         mul_c,
    input  logic [C_W-1:0]         mul_result,
    input  logic                   mul_overflow,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [C_W-1:0]         rsp_result,
    output logic                   rsp_overflow,
    output logic                   busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            ovf;
        logic [C_W-1:0]  result;
    } rsp_t;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    tag_t             tag1_q, tag1_d;
    tag_t             tag2_q, tag2_d;
    logic [C_W-1:0]   mul_c_q, mul_c_d;
    rsp_t             mem_q [FIFO_DEPTH];
    rsp_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]       inflight_c;
    logic             issue_ok_c;
    logic             grant_vld_c;
    logic [ID_W-1:0]  grant_id_c;
    logic [ID_W-1:0]  scan_idx_c;
    logic [C_W-1:0]   c_sel_c;
    logic             push_c;
    logic             pop_c;
    rsp_t             head_c;

    // Credits: ops still in the unit plus queued results must fit in the FIFO.
    always_comb begin
        inflight_c = 2'(tag1_q.vld) + 2'(tag2_q.vld);
        issue_ok_c = (32'(inflight_c) + 32'(count_q)) < FIFO_DEPTH;
    end

    // Round-robin scan starting at rr_ptr; no grant while reset is held.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        scan_idx_c  = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx_c = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_vld_c && req_valid[scan_idx_c]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = scan_idx_c;
            end
        end
        if (reset || !issue_ok_c) begin
            grant_vld_c = 1'b0;
            grant_id_c  = '0;
        end
    end

    // Operand mux for the granted requester; zero when idle.
    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        c_sel_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_vld_c && (grant_id_c == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                mul_a        = req_a[i*A_W +: A_W];
                mul_b        = req_b[i*A_W +: A_W];
                c_sel_c      = req_c[i*C_W +: C_W];
            end
        end
    end

    // Pointer advance, c skew by one cycle, and tag pipe matching unit latency.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld_c) begin
            rr_ptr_d = (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
        end
        mul_c_d    = grant_vld_c ? c_sel_c : '0;
        tag1_d.vld = grant_vld_c;
        tag1_d.id  = grant_id_c;
        tag2_d     = tag1_q;
    end

    // Result FIFO: stage-2 tag marks the cycle the unit's result is valid.
    always_comb begin
        push_c   = tag2_q.vld;
        pop_c    = (count_q != '0) && rsp_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            mem_d[wr_ptr_q].id     = tag2_q.id;
            mem_d[wr_ptr_q].ovf    = mul_overflow;
            mem_d[wr_ptr_q].result = mul_result;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            tag1_q   <= '0;
            tag2_q   <= '0;
            mul_c_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            mul_c_q  <= mul_c_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head fields are forced to zero when empty so stale entries never show.
    always_comb begin
        head_c       = mem_q[rd_ptr_q];
        rsp_valid    = (count_q != '0);
        rsp_id       = rsp_valid ? head_c.id : '0;
        rsp_result   = rsp_valid ? head_c.result : '0;
        rsp_overflow = rsp_valid ? head_c.ovf : 1'b0;
        busy         = (inflight_c != 2'd0) || rsp_valid;
        mul_c        = mul_c_q;
    end

    a_no_overrun: assert property (@(posedge clk) disable iff (reset)
        !(push_c && !pop_c && (count_q == CNT_W'(FIFO_DEPTH))));

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));

endmodule

// File: doc/mac_arbiter.md
Name: mac_arbiter

Overview:
- Shares one multiply-add unit between NUM_REQ requesters; the unit computes result = a*b + c with overflow.
- Unit timing: a/b sampled at edge T+1, c added in cycle T+1, result and overflow registered at edge T+2. Latency is 2, with no stall input.
- The block arbitrates round-robin and drives the unit's operands with the correct skew.
- It tags in-flight operations, collects results in an output FIFO with valid/ready, and uses credits so the non-stallable pipeline never overruns the FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 18, width of a and b.
- C_W, 36, width of c and result.
- FIFO_DEPTH, 4, result FIFO entries (>=4, power of 2).
- ID_W, 2, requester id width (clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_W  packed a operands; requester i at [i*A_W +: A_W].
- req_b  in  NUM_REQ*A_W  packed b operands.
- req_c  in  NUM_REQ*C_W  packed c operands.
- mul_a  out  A_W  to unit a.
- mul_b  out  A_W  to unit b.
- mul_c  out  C_W  to unit c.
- mul_result  in  C_W  from unit result.
- mul_overflow  in  1  from unit overflow.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  requester id of head.
- rsp_result  out  C_W  result of head.
- rsp_overflow  out  1  overflow of head.
- busy  out  1  any op in flight or FIFO non-empty.

Behaviour:
- Reset: clk is the only clock. reset is asynchronous and active-high; it clears the following, all outputs going to 0:
  - rr_ptr (to 0), tag pipe, skew register, FIFO pointers and count;
  - req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, busy, mul_c.
- Reset mid-operation: all in-flight ops and FIFO contents are discarded. Unit outputs arriving afterwards are ignored because the tag valids are 0.
- Credit: inflight = number of valid tag stages (0..2).
  - issue_ok = (inflight + fifo_count < FIFO_DEPTH), computed from current registered values; no same-cycle pop credit.
- Arbitration (combinational):
  - When issue_ok, grant the first set req_valid bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g] = 1 only for the granted index; all others 0.
  - No grant when issue_ok = 0 or no request.
- Issue cycle T (req_valid[g] & req_ready[g]):
  - mul_a/mul_b = req_a/req_b of g, combinational.
  - When no issue, mul_a/mul_b = 0.
  - rr_ptr <= (g+1) mod NUM_REQ; rr_ptr holds when there is no issue.
- Skew: mul_c is registered. It is set to req_c of g at edge T+1, so it is valid during cycle T+1; otherwise it is 0.
- Tag pipe: 2 stages of {valid, id}, shifting every cycle.
  - Stage 2 valid at cycle T+2 means the unit's result/overflow for that op are valid then.
  - That entry is pushed into the FIFO at edge T+3, so rsp_valid rises in cycle T+3.
- FIFO:
  - Entries are {id, overflow, result}; rsp_* reflect the head; rsp_valid = (count != 0).
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop keeps count unchanged, including when full.
  - Credits guarantee push never occurs with count == FIFO_DEPTH and no pop.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Throughput: with rsp_ready held 1 and continuous requests, one issue per cycle (steady inflight 2, count <= 1).
- Ordering: responses leave in issue order; each rsp carries its originating id.
- busy = (inflight != 0) | (count != 0).

Test Plan:
- Single op: requester 1 issues a=3, b=5, c=7 at cycle 0 with rsp_ready=1.
  - Expect mul_c=7 in cycle 1 only.
  - Expect rsp_valid in cycle 3 with id=1, result=22, overflow=0, then busy=0 from cycle 4.
- Overflow: a=b=2^18-1, c=2^36-1 -> result = (a*b + c) mod 2^36, overflow=1.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1.
  - Grants cycle 0,1,2,3 are ids 0,1,2,3, then 0 again.
  - One response per cycle from cycle 3, ids in the same order.
- Backpressure: rsp_ready=0 with all requesters valid.
  - Exactly 4 issues, then req_ready all 0 and FIFO full.
  - Raise rsp_ready: one pop per cycle, and issues resume with no lost or duplicated result.
- Pointer wrap: only requesters 3 and 0 valid, rr_ptr=3 -> grants alternate 3,0,3,0.
- Async reset: assert reset mid-cycle with 2 ops in flight and 2 FIFO entries.
  - Outputs go to 0 immediately.
  - After release, no stale rsp_valid appears; the next issue is granted from requester 0.
